// File: rtl/nes_mem_arb_pkg.sv
// Shared types and constants for the NES multi-port DDR3 front end.
package nes_mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        CMD_RD  = 2'd0,
        CMD_WR  = 2'd1,
        CMD_REF = 2'd2
    } cmd_e;

    localparam int unsigned MIN_WAIT       = 2;
    localparam logic [7:0]  TIMEOUT_RD_VAL = 8'hFF;

endpackage

// File: rtl/nes_mem_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first pending index at or after the pointer,
// wrapping. The pointer itself lives in the parent.
module rr_arbiter #(
    parameter int unsigned NPORTS = 3,
    parameter int unsigned IW     = $clog2(NPORTS)
) (
    input  logic [NPORTS-1:0] i_pend,
    input  logic [IW-1:0]     i_ptr,
    output logic [NPORTS-1:0] o_gnt_c,
    output logic [IW-1:0]     o_idx_c,
    output logic              o_valid_c
);

    always_comb begin
        int unsigned k;
        k         = 0;
        o_gnt_c   = '0;
        o_idx_c   = '0;
        o_valid_c = 1'b0;
        for (int unsigned i = 0; i < NPORTS; i++) begin
            k = 32'(i_ptr) + i;
            if (k >= NPORTS) begin
                k = k - NPORTS;
            end
            if (!o_valid_c && i_pend[IW'(k)]) begin
                o_valid_c        = 1'b1;
                o_gnt_c[IW'(k)]  = 1'b1;
                o_idx_c          = IW'(k);
            end
        end
    end

endmodule

// File: rtl/nes_mem_arbiter.sv
// Multi-port byte client front end for ddr3_controller: sticky request slots,
// refresh priority, round-robin grant, busy/data_ready completion tracking.
// Optional watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module nes_mem_arbiter
    import nes_mem_arb_pkg::*;
#(
    parameter int unsigned NPORTS  = 3,
    parameter int unsigned AW      = 22,
    parameter int unsigned MAW     = 26,
    parameter int unsigned TIMEOUT = 63
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [NPORTS-1:0]    req,
    input  logic [NPORTS-1:0]    we,
    input  logic [NPORTS*AW-1:0] addr,
    input  logic [NPORTS*8-1:0]  din,
    output logic [NPORTS*8-1:0]  dout,
    output logic [NPORTS-1:0]    ack,
    output logic [NPORTS-1:0]    pending,
    input  logic                 refresh,
    input  logic                 lane_hi,
    output logic                 ready,
    output logic                 timeout_err,
    output logic [MAW-1:0]       mem_addr,
    output logic                 mem_rd,
    output logic                 mem_wr,
    output logic                 mem_refresh,
    output logic [15:0]          mem_din,
    input  logic [15:0]          mem_dout,
    input  logic                 mem_busy,
    input  logic                 mem_data_ready
);

    localparam int unsigned IW = $clog2(NPORTS);
`ifdef MEM_ARB_TIMEOUT_EN
    localparam int unsigned CW = ($clog2(TIMEOUT + 1) > 6) ? $clog2(TIMEOUT + 1) : 6;
`else
    localparam int unsigned CW = 2;
`endif

    if (NPORTS < 2 || NPORTS > 8 || MAW < AW || TIMEOUT < MIN_WAIT) begin : g_bad_cfg
        $error("nes_mem_arbiter: unsupported parameter set");
    end

    state_e            r_state, w_state_nxt;
    logic [NPORTS-1:0] r_vld, r_we, r_ack;
    logic [AW-1:0]     r_addr [NPORTS];
    logic [7:0]        r_din  [NPORTS];
    logic [7:0]        r_dout [NPORTS];
    logic              r_ref_vld, r_ready;
    logic [IW-1:0]     r_ptr, r_port;
    cmd_e              r_kind;
    logic [CW-1:0]     r_wcnt;
    logic [MAW-1:0]    r_mem_addr;
    logic              r_mem_rd, r_mem_wr, r_mem_refresh;
    logic [15:0]       r_mem_din;

    logic [NPORTS-1:0] w_gnt;
    logic [IW-1:0]     w_idx;
    logic              w_arb_vld, w_issue_ref, w_issue_cli, w_done, w_tmo;
    logic              w_sel_we;
    logic [AW-1:0]     w_sel_addr;
    logic [7:0]        w_sel_din, w_lane_byte;

    rr_arbiter #(.NPORTS(NPORTS), .IW(IW)) u_rr (
        .i_pend    (r_vld),
        .i_ptr     (r_ptr),
        .o_gnt_c   (w_gnt),
        .o_idx_c   (w_idx),
        .o_valid_c (w_arb_vld)
    );

    // Mux out the winning slot's payload.
    always_comb begin
        w_sel_we   = 1'b0;
        w_sel_addr = '0;
        w_sel_din  = '0;
        for (int p = 0; p < NPORTS; p++) begin
            if (w_gnt[p]) begin
                w_sel_we   = r_we[p];
                w_sel_addr = r_addr[p];
                w_sel_din  = r_din[p];
            end
        end
    end

    assign w_lane_byte = lane_hi ? mem_dout[15:8] : mem_dout[7:0];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_issue_ref = 1'b0;
        w_issue_cli = 1'b0;
        w_done      = 1'b0;
        w_tmo       = 1'b0;
        case (r_state)
            ST_INIT: begin
                if (!mem_busy) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (r_ref_vld) begin
                    w_issue_ref = 1'b1;
                    w_state_nxt = ST_WAIT;
                end else if (w_arb_vld) begin
                    w_issue_cli = 1'b1;
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Reads finish on data_ready; writes/refresh once busy has had time to assert and drop.
                if (r_kind == CMD_RD) begin
                    w_done = mem_data_ready;
                end else begin
                    w_done = !mem_busy && (r_wcnt >= CW'(MIN_WAIT));
                end
`ifdef MEM_ARB_TIMEOUT_EN
                w_tmo = !w_done && (r_wcnt == CW'(TIMEOUT));
`endif
                if (w_done || w_tmo) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_INIT;
        endcase
    end

    // Client request slots: capture when empty, cleared on grant.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_vld <= '0;
            r_we  <= '0;
            for (int p = 0; p < NPORTS; p++) begin
                r_addr[p] <= '0;
                r_din[p]  <= '0;
            end
        end else begin
            for (int p = 0; p < NPORTS; p++) begin
                if (w_issue_cli && w_gnt[p]) begin
                    r_vld[p] <= 1'b0;
                end else if (req[p] && !r_vld[p]) begin
                    r_vld[p]  <= 1'b1;
                    r_we[p]   <= we[p];
                    r_addr[p] <= addr[p*AW +: AW];
                    r_din[p]  <= din[p*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ref_vld <= 1'b0;
        end else if (w_issue_ref) begin
            r_ref_vld <= 1'b0;
        end else if (refresh) begin
            r_ref_vld <= 1'b1;
        end
    end

    // Backend command issue and outstanding-transaction bookkeeping.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_mem_rd      <= 1'b0;
            r_mem_wr      <= 1'b0;
            r_mem_refresh <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_din     <= '0;
            r_kind        <= CMD_RD;
            r_port        <= '0;
            r_ptr         <= '0;
            r_ready       <= 1'b0;
        end else begin
            r_mem_rd      <= 1'b0;
            r_mem_wr      <= 1'b0;
            r_mem_refresh <= 1'b0;
            r_ready       <= (w_state_nxt != ST_INIT);
            if (w_issue_ref) begin
                r_mem_refresh <= 1'b1;
                r_kind        <= CMD_REF;
            end else if (w_issue_cli) begin
                r_mem_rd   <= !w_sel_we;
                r_mem_wr   <= w_sel_we;
                r_mem_addr <= MAW'(w_sel_addr);
                r_mem_din  <= {w_sel_din, w_sel_din};
                r_kind     <= w_sel_we ? CMD_WR : CMD_RD;
                r_port     <= w_idx;
                r_ptr      <= (w_idx == IW'(NPORTS - 1)) ? '0 : w_idx + IW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wcnt <= '0;
        end else if (w_issue_ref || w_issue_cli) begin
            r_wcnt <= '0;
        end else if (r_state == ST_WAIT && r_wcnt != '1) begin
            r_wcnt <= r_wcnt + CW'(1);
        end
    end

    // Completion: ack pulse and read-data capture.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ack <= '0;
            for (int p = 0; p < NPORTS; p++) begin
                r_dout[p] <= '0;
            end
        end else begin
            r_ack <= '0;
            for (int p = 0; p < NPORTS; p++) begin
                if ((w_done || w_tmo) && r_kind != CMD_REF && r_port == IW'(p)) begin
                    r_ack[p] <= 1'b1;
                    if (r_kind == CMD_RD) begin
                        r_dout[p] <= w_tmo ? TIMEOUT_RD_VAL : w_lane_byte;
                    end
                end
            end
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    logic r_terr;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_terr <= 1'b0;
        end else if (w_tmo) begin
            r_terr <= 1'b1;
        end
    end
    assign timeout_err = r_terr;
`else
    assign timeout_err = 1'b0;
`endif

    for (genvar g = 0; g < NPORTS; g++) begin : g_dout
        assign dout[g*8 +: 8] = r_dout[g];
    end

    assign ack         = r_ack;
    assign pending     = r_vld;
    assign ready       = r_ready;
    assign mem_addr    = r_mem_addr;
    assign mem_rd      = r_mem_rd;
    assign mem_wr      = r_mem_wr;
    assign mem_refresh = r_mem_refresh;
    assign mem_din     = r_mem_din;

endmodule

// File: tb/tb_nes_mem_arbiter.sv
// Randomized bench for nes_mem_arbiter with a transaction-level reference model
// and a reactive backend; default build (watchdog disabled).
module tb_nes_mem_arbiter;

    localparam int NP  = 3;
    localparam int AW  = 22;
    localparam int MAW = 26;

    logic              clk = 1'b0;
    logic              resetn;
    logic [NP-1:0]     req, we, ack, pending;
    logic [NP*AW-1:0]  addr;
    logic [NP*8-1:0]   din, dout;
    logic              refresh, lane_hi, ready, timeout_err;
    logic [MAW-1:0]    mem_addr;
    logic              mem_rd, mem_wr, mem_refresh;
    logic [15:0]       mem_din, mem_dout;
    logic              mem_busy, mem_data_ready;

    always #5 clk = ~clk;

    nes_mem_arbiter #(.NPORTS(NP), .AW(AW), .MAW(MAW), .TIMEOUT(63)) dut (
        .clk(clk), .resetn(resetn), .req(req), .we(we), .addr(addr), .din(din),
        .dout(dout), .ack(ack), .pending(pending), .refresh(refresh), .lane_hi(lane_hi),
        .ready(ready), .timeout_err(timeout_err), .mem_addr(mem_addr), .mem_rd(mem_rd),
        .mem_wr(mem_wr), .mem_refresh(mem_refresh), .mem_din(mem_din), .mem_dout(mem_dout),
        .mem_busy(mem_busy), .mem_data_ready(mem_data_ready)
    );

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: phase 0=not initialised, 1=free, 2=transaction outstanding.
    int            m_phase, m_ptr, o_kind, o_port, o_age;
    bit [NP-1:0]   m_vld, m_we;
    bit [AW-1:0]   m_addr [NP];
    bit [7:0]      m_din  [NP];
    bit            m_ref;
    bit            e_ready, e_rd, e_wr, e_ref;
    bit [NP-1:0]   e_ack;
    bit [7:0]      e_dout [NP];
    bit [MAW-1:0]  e_maddr;
    bit [15:0]     e_mdin;

    always @(posedge clk or negedge resetn) begin : model
        bit [NP-1:0] cap;
        bit          cap_ref, fin;
        int          p;
        if (!resetn) begin
            m_phase = 0; m_ptr = 0; o_kind = 0; o_port = 0; o_age = 0;
            m_vld = '0; m_we = '0; m_ref = 0;
            for (int i = 0; i < NP; i++) begin
                m_addr[i] = '0; m_din[i] = '0; e_dout[i] = '0;
            end
            e_ready = 0; e_ack = '0; e_rd = 0; e_wr = 0; e_ref = 0;
            e_maddr = '0; e_mdin = '0;
        end else begin
            cap     = req & ~m_vld;
            cap_ref = refresh && !m_ref;
            e_ack = '0; e_rd = 0; e_wr = 0; e_ref = 0;
            if (m_phase == 0) begin
                if (!mem_busy) m_phase = 1;
            end else if (m_phase == 1) begin
                if (m_ref) begin
                    m_ref = 0; e_ref = 1; o_kind = 2; o_age = 0; m_phase = 2;
                end else begin
                    for (int i = 0; i < NP; i++) begin
                        p = (m_ptr + i) % NP;
                        if (m_phase == 1 && m_vld[p]) begin
                            m_vld[p] = 0;
                            e_rd     = !m_we[p];
                            e_wr     = m_we[p];
                            e_maddr  = MAW'(m_addr[p]);
                            e_mdin   = {m_din[p], m_din[p]};
                            o_kind   = m_we[p] ? 1 : 0;
                            o_port   = p;
                            o_age    = 0;
                            m_ptr    = (p + 1) % NP;
                            m_phase  = 2;
                        end
                    end
                end
            end else begin
                fin = (o_kind == 0) ? mem_data_ready : (!mem_busy && o_age >= 2);
                if (fin) begin
                    if (o_kind != 2) e_ack[o_port] = 1;
                    if (o_kind == 0) e_dout[o_port] = lane_hi ? mem_dout[15:8] : mem_dout[7:0];
                    m_phase = 1;
                end else begin
                    o_age++;
                end
            end
            for (int i = 0; i < NP; i++) begin
                if (cap[i]) begin
                    m_vld[i]  = 1;
                    m_we[i]   = we[i];
                    m_addr[i] = addr[i*AW +: AW];
                    m_din[i]  = din[i*8 +: 8];
                end
            end
            if (cap_ref) m_ref = 1;
            e_ready = (m_phase != 0);
        end
    end

    // Reactive backend and observation logs.
    bit          bk_hold, bk_act, bk_rd, bk_fix, rnd_noise;
    int          bk_cnt;
    logic [15:0] bk_data;
    int          cmd_log [$];
    logic [15:0] wdin_log [$];
    int          ack_log [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int lg(input int i);
        return (i < cmd_log.size()) ? cmd_log[i] : -2;
    endfunction

    task automatic tick();
        @(negedge clk);
        chk("ready",       32'(ready),       32'(e_ready));
        chk("pending",     32'(pending),     32'(m_vld));
        chk("ack",         32'(ack),         32'(e_ack));
        for (int p = 0; p < NP; p++)
            chk($sformatf("dout%0d", p), 32'(dout[p*8 +: 8]), 32'(e_dout[p]));
        chk("mem_rd",      32'(mem_rd),      32'(e_rd));
        chk("mem_wr",      32'(mem_wr),      32'(e_wr));
        chk("mem_refresh", 32'(mem_refresh), 32'(e_ref));
        chk("mem_addr",    32'(mem_addr),    32'(e_maddr));
        chk("mem_din",     32'(mem_din),     32'(e_mdin));
        chk("timeout_err", 32'(timeout_err), 32'(0));
        if (mem_refresh) cmd_log.push_back(-1);
        if (mem_rd || mem_wr) cmd_log.push_back(int'(mem_addr));
        if (mem_wr) wdin_log.push_back(mem_din);
        for (int p = 0; p < NP; p++) if (ack[p]) ack_log.push_back(p);
        req = '0;
        refresh = 1'b0;
        if (mem_rd || mem_wr || mem_refresh) begin
            bk_act = 1; bk_rd = mem_rd; bk_cnt = $urandom_range(0, 4);
        end
        mem_data_ready = 1'b0;
        if (!bk_fix) lane_hi = 1'($urandom_range(0, 1));
        if (bk_hold) begin
            mem_busy = 1'b1;
        end else if (bk_act) begin
            if (bk_cnt > 0) begin
                mem_busy = 1'b1;
                bk_cnt--;
            end else begin
                mem_busy = 1'b0;
                bk_act   = 0;
                if (bk_rd) begin
                    mem_data_ready = 1'b1;
                    mem_dout = bk_fix ? bk_data : 16'($urandom);
                end
            end
        end else begin
            mem_busy       = rnd_noise && ($urandom_range(0, 9) == 0);
            mem_data_ready = rnd_noise && ($urandom_range(0, 7) == 0);
            mem_dout       = 16'($urandom);
        end
    endtask

    task automatic wait_ready(input int budget);
        for (int k = 0; k < budget && !ready; k++) tick();
        chk("wait_ready", 32'(ready), 32'(1));
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        do begin
            tick();
            k++;
        end while (k < budget && !(m_phase == 1 && m_vld == '0 && !m_ref));
        chk("wait_idle", 32'(m_phase == 1 && m_vld == '0 && !m_ref), 32'(1));
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        bk_act = 0;
        mem_busy = 1'b0;
        repeat (2) tick();
        resetn = 1'b1;
    endtask

    initial begin
        int got, viol;
        resetn = 1'b0; req = '0; we = '0; addr = '0; din = '0; refresh = 1'b0;
        lane_hi = 1'b0; mem_dout = '0; mem_busy = 1'b1; mem_data_ready = 1'b0;
        bk_hold = 1; bk_act = 0; bk_rd = 0; bk_fix = 0; rnd_noise = 0; bk_cnt = 0; bk_data = '0;

        repeat (3) @(negedge clk);
        chk("rst_ready",   32'(ready),   32'(0));
        chk("rst_pending", 32'(pending), 32'(0));
        chk("rst_mem_cmd", 32'({mem_rd, mem_wr, mem_refresh}), 32'(0));
        chk("rst_dout",    32'(dout),    32'(0));

        // Init: backend busy for 100 cycles, nothing may be issued
        resetn = 1'b1;
        cmd_log.delete();
        repeat (100) tick();
        chk("init_ready_low", 32'(ready), 32'(0));
        chk("init_no_cmds",   32'(cmd_log.size()), 32'(0));
        bk_hold = 0;
        mem_busy = 1'b0;
        tick();
        chk("ready_rise", 32'(ready), 32'(1));

        // Single read on port 1
        bk_fix = 1; bk_data = 16'hA55A; lane_hi = 1'b0;
        cmd_log.delete();
        addr[1*AW +: AW] = 22'h200010; we[1] = 1'b0; req[1] = 1'b1;
        got = 0;
        for (int k = 0; k < 30 && got == 0; k++) begin
            tick();
            if (ack[1]) got = 1;
        end
        chk("rd_ack_seen", 32'(got), 32'(1));
        chk("rd_dout1",    32'(dout[15:8]), 32'(8'h5A));
        chk("rd_mem_addr", 32'(lg(0)), 32'(26'h0200010));
        tick();
        chk("rd_ack_pulse", 32'(ack[1]), 32'(0));
        bk_fix = 0;

        // Round-robin with all ports continuously requesting
        do_reset();
        wait_ready(10);
        cmd_log.delete(); ack_log.delete();
        for (int k = 0; k < 80; k++) begin
            we = '1;
            for (int p = 0; p < NP; p++) addr[p*AW +: AW] = AW'(p);
            req = '1;
            tick();
        end
        wait_idle(200);
        for (int i = 0; i < 6; i++) chk($sformatf("rr_order%0d", i), 32'(lg(i)), 32'(i % NP));
        viol = 0;
        for (int i = 0; i + 1 < ack_log.size(); i++) if (ack_log[i] == ack_log[i+1]) viol++;
        chk("rr_no_double_ack", 32'(viol), 32'(0));

        // Refresh priority over simultaneous port 0 / port 2 requests
        do_reset();
        wait_ready(10);
        cmd_log.delete(); ack_log.delete();
        we = '1;
        for (int p = 0; p < NP; p++) addr[p*AW +: AW] = AW'(p);
        refresh = 1'b1; req[0] = 1'b1; req[2] = 1'b1;
        wait_idle(200);
        chk("ref_first",  32'(lg(0)), 32'(-1));
        chk("ref_then_0", 32'(lg(1)), 32'(0));
        chk("ref_then_2", 32'(lg(2)), 32'(2));
        chk("ref_ncmds",  32'(cmd_log.size()), 32'(3));
        chk("ref_noack",  32'(ack_log.size()), 32'(2));

        // Drop rule: second request while the slot is still full is ignored
        cmd_log.delete(); wdin_log.delete();
        we[2] = 1'b1; addr[2*AW +: AW] = 22'd2; din[2*8 +: 8] = 8'h11; req[2] = 1'b1;
        tick();
        din[2*8 +: 8] = 8'h22; req[2] = 1'b1;
        wait_idle(100);
        chk("drop_ncmds", 32'(cmd_log.size()), 32'(1));
        chk("drop_din",   32'(wdin_log.size() > 0 ? wdin_log[0] : 16'h0), 32'(16'h1111));

        // Randomized traffic with one asynchronous reset in the middle
        rnd_noise = 1;
        for (int k = 0; k < 3000; k++) begin
            if (k == 1500) begin
                do_reset();
            end
            if (ready) begin
                for (int p = 0; p < NP; p++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        req[p] = 1'b1;
                        we[p]  = 1'($urandom_range(0, 1));
                        addr[p*AW +: AW] = AW'($urandom);
                        din[p*8 +: 8]    = 8'($urandom);
                    end
                end
                if ($urandom_range(0, 19) == 0) refresh = 1'b1;
            end
            tick();
        end
        rnd_noise = 0;
        wait_idle(300);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
